// File: rtl/wb_int_pkg.sv
// -----------------------------------------------------------------------------
// wb_int_pkg
// Shared constants for the Wishbone interrupt controller.
//   REG_*           : register offsets, decoded from ADDR[3:2]
//   CAUSE_VALID_BIT : bit of the CAUSE register that mirrors INT
//   MAX_CH          : largest supported channel count
// -----------------------------------------------------------------------------
package wb_int_pkg;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_CAUSE   = 2'd2;
  localparam logic [1:0] REG_MODE    = 2'd3;

  localparam int CAUSE_VALID_BIT = 31;
  localparam int MAX_CH          = 32;

  typedef logic [4:0] cause_idx_t;

endpackage : wb_int_pkg

// File: rtl/int_prio_enc.sv
// -----------------------------------------------------------------------------
// int_prio_enc
// Combinational lowest-set-bit encoder. Bit 0 has the highest priority.
//   req_i   [N_CH] : request vector
//   valid_o        : any request set
//   idx_o   [5]    : index of the lowest set bit, 0 when no request is set
// -----------------------------------------------------------------------------
module int_prio_enc
  import wb_int_pkg::*;
#(
  parameter int N_CH = 6
) (
  input  logic [N_CH-1:0] req_i,
  output logic            valid_o,
  output cause_idx_t      idx_o
);

  // Scan from the top down so that the lowest set bit is the last to write.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = cause_idx_t'(i);
      end
    end
  end

endmodule : int_prio_enc

// File: rtl/wb_int_ctrl.sv
// -----------------------------------------------------------------------------
// wb_int_ctrl
// Wishbone-slave interrupt controller: per-channel edge/level capture,
// pending latch, mask and fixed priority (channel 0 highest).
//
// Ports
//   clk            : system clock
//   RSTN           : asynchronous active-low reset
//   STB, WE        : Wishbone strobe / write enable
//   ADDR   [32]    : byte address, only ADDR[3:2] decoded
//   DAT_I  [32]    : write data
//   DAT_O  [32]    : registered read data, held until the next access
//   ACK            : Wishbone acknowledge, one wait state per access
//   irq_in [N_CH]  : device interrupt lines, active high
//   INT            : interrupt request to the CPU
//   CAUSE  [32]    : index of the winning channel, zero-extended
//
// Register map (ADDR[3:2])
//   0 PENDING : read pending; write 1 clears edge-mode bits
//   1 MASK    : R/W, 1 = channel enabled
//   2 CAUSE   : RO, bit31 = INT, bits[4:0] = CAUSE
//   3 MODE    : R/W, 1 = edge, 0 = level
//
// Build option
//   INT_SYNC_EN : when defined, irq_in passes through a 2-flop synchronizer
//                 before capture (adds 2 cycles of INT latency).
// -----------------------------------------------------------------------------
module wb_int_ctrl
  import wb_int_pkg::*;
#(
  parameter int          N_CH     = 6,
  parameter logic [31:0] RST_MASK = 32'h0,
  parameter logic [31:0] RST_MODE = 32'h0
) (
  input  logic            clk,
  input  logic            RSTN,
  input  logic            STB,
  input  logic            WE,
  input  logic [31:0]     ADDR,
  input  logic [31:0]     DAT_I,
  output logic [31:0]     DAT_O,
  output logic            ACK,
  input  logic [N_CH-1:0] irq_in,
  output logic            INT,
  output logic [31:0]     CAUSE
);

  logic [N_CH-1:0] irq_s;
  logic [N_CH-1:0] irq_prev_q;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [N_CH-1:0] mode_q, mode_d;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] clr;
  logic [N_CH-1:0] masked;
  logic [N_CH-1:0] wdat;

  logic            ack_q;
  logic            int_q;
  cause_idx_t      cause_q;
  logic [31:0]     dat_o_q;
  logic [31:0]     rdata;

  logic            enc_valid;
  cause_idx_t      enc_idx;

  logic [1:0]      reg_sel;
  logic            acc_start;
  logic            wr_en;

  logic            unused_bits;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
`ifdef INT_SYNC_EN
  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign reg_sel   = ADDR[3:2];
  assign wdat      = DAT_I[N_CH-1:0];
  // An access starts on the first cycle STB is seen while ACK is still low;
  // all side effects are tied to that single edge.
  assign acc_start = STB & ~ack_q;
  assign wr_en     = acc_start & WE;

  // Address bits outside [3:2] are not decoded.
  assign unused_bits = ^{ADDR[31:4], ADDR[1:0], DAT_I};

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_PENDING: rdata = 32'(pend_q);
      REG_MASK:    rdata = 32'(mask_q);
      REG_CAUSE: begin
        rdata[CAUSE_VALID_BIT] = int_q;
        rdata[4:0]             = cause_q;
      end
      REG_MODE:    rdata = 32'(mode_q);
      default:     rdata = '0;
    endcase
  end

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    clr    = '0;
    if (wr_en) begin
      case (reg_sel)
        REG_PENDING: clr    = wdat & mode_q;  // level-mode bits ignore W1C
        REG_MASK:    mask_d = wdat;
        REG_MODE:    mode_d = wdat;
        default:     ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pending capture
  // ---------------------------------------------------------------------------
  assign rise = irq_s & ~irq_prev_q;

  // Edge channels: a new rising edge wins over a same-cycle clear.
  // Level channels: pending simply follows the (registered) line.
  assign pend_d = (mode_q & (rise | (pend_q & ~clr))) | (~mode_q & irq_s);

  assign masked = pend_q & mask_q;

  int_prio_enc #(
    .N_CH (N_CH)
  ) u_prio_enc (
    .req_i   (masked),
    .valid_o (enc_valid),
    .idx_o   (enc_idx)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      irq_prev_q <= '0;
      pend_q     <= '0;
      mask_q     <= RST_MASK[N_CH-1:0];
      mode_q     <= RST_MODE[N_CH-1:0];
      int_q      <= 1'b0;
      cause_q    <= '0;
      ack_q      <= 1'b0;
      dat_o_q    <= '0;
    end else begin
      irq_prev_q <= irq_s;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      int_q      <= enc_valid;
      cause_q    <= enc_idx;
      // ACK follows STB one cycle late, giving exactly one wait state and
      // dropping the cycle after STB falls.
      ack_q      <= STB;
      if (acc_start) begin
        dat_o_q <= rdata;
      end
    end
  end

  assign DAT_O = dat_o_q;
  assign ACK   = ack_q;
  assign INT   = int_q;
  assign CAUSE = {27'd0, cause_q};

endmodule : wb_int_ctrl

// File: tb/tb_wb_int_ctrl.sv
module tb_wb_int_ctrl;

  logic        clk   = 1'b0;
  logic        RSTN  = 1'b0;
  logic        STB   = 1'b0;
  logic        WE    = 1'b0;
  logic [31:0] ADDR  = '0;
  logic [31:0] DAT_I = '0;
  logic [5:0]  irq_in = '0;
  logic [31:0] DAT_O;
  logic        ACK;
  logic        INT;
  logic [31:0] CAUSE;

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  wb_int_ctrl #(
    .N_CH     (6),
    .RST_MASK (32'h0),
    .RST_MODE (32'h0)
  ) dut (
    .clk    (clk),
    .RSTN   (RSTN),
    .STB    (STB),
    .WE     (WE),
    .ADDR   (ADDR),
    .DAT_I  (DAT_I),
    .DAT_O  (DAT_O),
    .ACK    (ACK),
    .irq_in (irq_in),
    .INT    (INT),
    .CAUSE  (CAUSE)
  );

  // One complete access: STB raised after an edge, ACK on the next edge,
  // STB dropped, ACK gone one edge later. Returns 1 time unit after that edge.
  task automatic bus(input logic we, input logic [3:0] a, input logic [31:0] wd,
                     output logic [31:0] rdv);
    @(posedge clk); #1;
    STB = 1'b1; WE = we; ADDR = {28'd0, a}; DAT_I = wd;
    vecs++;
    if (ACK !== 1'b0) begin
      errs++; $display("FAIL bus_ack_pre: got %b expected 0", ACK);
    end
    @(posedge clk); #1;
    vecs++;
    if (ACK !== 1'b1) begin
      errs++; $display("FAIL bus_ack_high: got %b expected 1", ACK);
    end
    rdv = DAT_O;
    STB = 1'b0; WE = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (ACK !== 1'b0) begin
      errs++; $display("FAIL bus_ack_drop: got %b expected 0", ACK);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({ACK, INT, CAUSE, DAT_O} !== 66'd0) begin
      errs++; $display("FAIL reset_outputs: got ack=%b int=%b cause=%h dat=%h expected all 0",
                       ACK, INT, CAUSE, DAT_O);
    end
    #2 RSTN = 1'b1;
    bus(1'b0, 4'h4, 32'h0, rd);
    vecs++;
    if (rd !== 32'h0) begin
      errs++; $display("FAIL reset_mask: got %h expected %h", rd, 32'h0);
    end
    bus(1'b0, 4'hC, 32'h0, rd);
    vecs++;
    if (rd !== 32'h0) begin
      errs++; $display("FAIL reset_mode: got %h expected %h", rd, 32'h0);
    end
    // Level mode by default: pending follows irq_in[3] while held, mask blocks INT.
    irq_in = 6'h08;
    bus(1'b0, 4'h0, 32'h0, rd);
    vecs++;
    if (rd !== 32'h08) begin
      errs++; $display("FAIL masked_pending: got %h expected %h", rd, 32'h08);
    end
    vecs++;
    if (INT !== 1'b0) begin
      errs++; $display("FAIL masked_int: got %b expected 0", INT);
    end
    irq_in = 6'h00;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_enable_clear();
    bus(1'b1, 4'h4, 32'hFFFF_FFFF, rd);
    bus(1'b0, 4'h4, 32'h0, rd);
    vecs++;
    if (rd !== 32'h3F) begin
      errs++; $display("FAIL mask_width: got %h expected %h", rd, 32'h3F);
    end
    bus(1'b1, 4'hC, 32'h3F, rd);
    @(posedge clk); #1; irq_in = 6'h08;
    @(posedge clk); #1; irq_in = 6'h00;
    vecs++;
    if (INT !== 1'b0) begin
      errs++; $display("FAIL int_latency_early: got %b expected 0", INT);
    end
    @(posedge clk); #1;
    vecs++;
    if (INT !== 1'b1 || CAUSE !== 32'd3) begin
      errs++; $display("FAIL edge_irq3: got int=%b cause=%0d expected int=1 cause=3", INT, CAUSE);
    end
    bus(1'b1, 4'h0, 32'h08, rd);
    vecs++;
    if (INT !== 1'b0 || CAUSE !== 32'd0) begin
      errs++; $display("FAIL w1c_clear: got int=%b cause=%0d expected int=0 cause=0", INT, CAUSE);
    end
  endtask

  task automatic test_priority();
    @(posedge clk); #1; irq_in = 6'h12;
    @(posedge clk); #1; irq_in = 6'h00;
    @(posedge clk); #1;
    vecs++;
    if (INT !== 1'b1 || CAUSE !== 32'd1) begin
      errs++; $display("FAIL prio_1_over_4: got int=%b cause=%0d expected int=1 cause=1", INT, CAUSE);
    end
    bus(1'b0, 4'h8, 32'h0, rd);
    vecs++;
    if (rd !== 32'h8000_0001) begin
      errs++; $display("FAIL cause_reg: got %h expected %h", rd, 32'h8000_0001);
    end
    bus(1'b0, 4'h0, 32'h0, rd);
    vecs++;
    if (rd !== 32'h12) begin
      errs++; $display("FAIL prio_pending: got %h expected %h", rd, 32'h12);
    end
    bus(1'b1, 4'h0, 32'h02, rd);
    vecs++;
    if (INT !== 1'b1 || CAUSE !== 32'd4) begin
      errs++; $display("FAIL prio_after_clr: got int=%b cause=%0d expected int=1 cause=4", INT, CAUSE);
    end
    bus(1'b1, 4'h0, 32'h10, rd);
    vecs++;
    if (INT !== 1'b0) begin
      errs++; $display("FAIL prio_all_clr: got %b expected 0", INT);
    end
  endtask

  task automatic test_level();
    bus(1'b1, 4'hC, 32'h0, rd);
    irq_in = 6'h04;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vecs++;
    if (INT !== 1'b1 || CAUSE !== 32'd2) begin
      errs++; $display("FAIL level_irq2: got int=%b cause=%0d expected int=1 cause=2", INT, CAUSE);
    end
    bus(1'b1, 4'h0, 32'h04, rd);
    vecs++;
    if (INT !== 1'b1 || CAUSE !== 32'd2) begin
      errs++; $display("FAIL level_w1c_ignored: got int=%b cause=%0d expected int=1 cause=2", INT, CAUSE);
    end
    bus(1'b0, 4'h0, 32'h0, rd);
    vecs++;
    if (rd !== 32'h04) begin
      errs++; $display("FAIL level_pending: got %h expected %h", rd, 32'h04);
    end
    irq_in = 6'h00;
    @(posedge clk); #1;
    vecs++;
    if (INT !== 1'b1) begin
      errs++; $display("FAIL level_release_early: got %b expected 1", INT);
    end
    @(posedge clk); #1;
    vecs++;
    if (INT !== 1'b0) begin
      errs++; $display("FAIL level_release: got %b expected 0", INT);
    end
  endtask

  task automatic test_race();
    bus(1'b1, 4'hC, 32'h3F, rd);
    @(posedge clk); #1;
    STB = 1'b1; WE = 1'b1; ADDR = 32'h0; DAT_I = 32'h01; irq_in = 6'h01;
    @(posedge clk); #1;
    vecs++;
    if (ACK !== 1'b1) begin
      errs++; $display("FAIL race_ack: got %b expected 1", ACK);
    end
    STB = 1'b0; WE = 1'b0; irq_in = 6'h00;
    @(posedge clk); #1;
    vecs++;
    if (INT !== 1'b1 || CAUSE !== 32'd0) begin
      errs++; $display("FAIL race_int: got int=%b cause=%0d expected int=1 cause=0", INT, CAUSE);
    end
    bus(1'b0, 4'h0, 32'h0, rd);
    vecs++;
    if (rd !== 32'h01) begin
      errs++; $display("FAIL race_pending: got %h expected %h", rd, 32'h01);
    end
    bus(1'b1, 4'h0, 32'h01, rd);
    vecs++;
    if (INT !== 1'b0) begin
      errs++; $display("FAIL race_cleanup: got %b expected 0", INT);
    end
  endtask

  task automatic test_handshake();
    @(posedge clk); #1;
    STB = 1'b1; WE = 1'b1; ADDR = 32'h4; DAT_I = 32'h05;
    vecs++;
    if (ACK !== 1'b0) begin
      errs++; $display("FAIL hold_ack_c1: got %b expected 0", ACK);
    end
    @(posedge clk); #1;
    DAT_I = 32'h3A;
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if (ACK !== 1'b1) begin
        errs++; $display("FAIL hold_ack_c%0d: got %b expected 1", k + 2, ACK);
      end
      @(posedge clk); #1;
    end
    STB = 1'b0; WE = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (ACK !== 1'b0) begin
      errs++; $display("FAIL hold_ack_drop: got %b expected 0", ACK);
    end
    bus(1'b0, 4'h4, 32'h0, rd);
    vecs++;
    if (rd !== 32'h05) begin
      errs++; $display("FAIL single_write: got %h expected %h", rd, 32'h05);
    end
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (DAT_O !== 32'h05) begin
      errs++; $display("FAIL dat_o_hold: got %h expected %h", DAT_O, 32'h05);
    end
    // Reset in the middle of an access.
    @(posedge clk); #1;
    STB = 1'b1; WE = 1'b1; ADDR = 32'h4; DAT_I = 32'h2A;
    @(posedge clk); #1;
    #2 RSTN = 1'b0;
    #1;
    vecs++;
    if (ACK !== 1'b0 || DAT_O !== 32'h0) begin
      errs++; $display("FAIL reset_mid_access: got ack=%b dat=%h expected ack=0 dat=0", ACK, DAT_O);
    end
    STB = 1'b0; WE = 1'b0;
    #2 RSTN = 1'b1;
    bus(1'b0, 4'h4, 32'h0, rd);
    vecs++;
    if (rd !== 32'h0) begin
      errs++; $display("FAIL reset_mask_restore: got %h expected %h", rd, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_enable_clear();
    test_priority();
    test_level();
    test_race();
    test_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_wb_int_ctrl
